// File: rtl/serial_mem_slave.sv
// Bit-serial memory slave: address/data frames arrive MSB first over a valid/ready
// handshake and address a MEM_DEPTH-word register array mapped at BASE_ADDR.
module serial_mem_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int BASE_ADDR  = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid,
  output logic slave_err
);

  localparam int CNT_W = $clog2(ADDR_WIDTH + DATA_WIDTH + 1);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // The counter runs across address and data fields, so the data field ends at A+D-1.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADDR_WIDTH + DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ,
    SEND
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]      bit_cnt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  mode_reg;
  logic                  eff_mode;

  logic [ADDR_WIDTH:0]   offset;
  logic                  in_range;
  logic [IDX_W-1:0]      word_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // One extra bit keeps the subtraction and the upper-bound compare from wrapping.
  assign offset   = {1'b0, addr_reg} - BASE_EXT;
  assign in_range = ({1'b0, addr_reg} >= BASE_EXT) && (offset < DEPTH_EXT);
  assign word_idx = offset[IDX_W-1:0];

  // On the first address bit the latch has not been loaded yet, so use the live input.
  assign eff_mode = (bit_cnt == '0) ? mode : mode_reg;

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state is assigned before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (master_valid) next_state = ADDR;
      end
      ADDR: begin
        if (!master_valid) begin
          next_state = IDLE;
        end else if (bit_cnt == ADDR_LAST) begin
          next_state = eff_mode ? DATA : READ;
        end
      end
      DATA: begin
        if (!master_valid) begin
          next_state = IDLE;
        end else if (bit_cnt == DATA_LAST) begin
          next_state = WRITE;
        end
      end
      WRITE: next_state = IDLE;
      READ:  next_state = SEND;
      SEND: begin
        if (master_ready && (bit_cnt == SEND_LAST)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      shift_reg <= '0;
      mode_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: bit_cnt <= '0;
        ADDR: begin
          if (master_valid) begin
            if (bit_cnt == '0) mode_reg <= mode;
            addr_reg <= {addr_reg[ADDR_WIDTH-2:0], wr_bus};
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (master_valid) begin
            data_reg <= {data_reg[DATA_WIDTH-2:0], wr_bus};
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end
        end
        READ: begin
          shift_reg <= in_range ? mem[word_idx] : '0;
          bit_cnt   <= '0;
        end
        SEND: begin
          if (master_ready) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; clearing it would turn it into a large
  // reset-loaded flop bank instead of plain storage. Reset still blocks the write.
  always_ff @(posedge clk) begin
    if (rstn && (state == WRITE) && in_range) begin
      mem[word_idx] <= data_reg;
    end
  end

  assign slave_ready = (state == ADDR) || (state == DATA);
  assign slave_valid = (state == SEND);
  assign rd_bus      = (state == SEND) && shift_reg[DATA_WIDTH-1];
  assign slave_err   = ((state == WRITE) || (state == READ)) && !in_range;

endmodule

// File: tb/tb_serial_mem_slave.sv
// Self-checking bench for serial_mem_slave: directed frames plus randomized traffic
// checked against an array model of the address map.
module tb_serial_mem_slave;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int BASE  = 0;

  logic clk = 1'b0;
  logic rstn, mode, wr_bus, master_valid, master_ready;
  logic rd_bus, slave_ready, slave_valid, slave_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_written [DEPTH];

  always #5 clk = ~clk;

  serial_mem_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mode        (mode),
    .wr_bus      (wr_bus),
    .master_valid(master_valid),
    .master_ready(master_ready),
    .rd_bus      (rd_bus),
    .slave_ready (slave_ready),
    .slave_valid (slave_valid),
    .slave_err   (slave_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_range(input int addr);
    return (addr >= BASE) && (addr < BASE + DEPTH);
  endfunction

  // Present one bit and hold it until the slave shows ready; it is taken on the next edge.
  task automatic put_bit(input logic b);
    int t = 0;
    master_valid = 1'b1;
    wr_bus       = b;
    while (!slave_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("hs_ready", slave_ready, 1);
    @(negedge clk);
  endtask

  // mode is scrambled after the first bit: only the first handshake may count.
  task automatic send_addr(input logic [AW-1:0] addr, input logic m);
    mode = m;
    for (int i = AW - 1; i >= 0; i--) begin
      put_bit(addr[i]);
      mode = 1'($urandom_range(0, 1));
    end
  endtask

  // Returns at the falling edge inside the WRITE cycle.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    send_addr(addr, 1'b1);
    for (int i = DW - 1; i >= 0; i--) put_bit(data[i]);
    master_valid = 1'b0;
    wr_bus       = 1'b0;
    check("wr_ready_low", slave_ready, 0);
    check("wr_err", slave_err, 32'(!model_in_range(int'(addr))));
    if (model_in_range(int'(addr))) begin
      model_mem[int'(addr) - BASE]     = data;
      model_written[int'(addr) - BASE] = 1'b1;
    end
  endtask

  // ready_mode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic do_read(input logic [AW-1:0] addr, input int ready_mode);
    logic [DW-1:0] w = '0;
    logic [DW-1:0] exp;
    logic          prev = 1'b0;
    logic          held = 1'b0;
    logic          mr;
    int            got = 0;
    int            t = 0;
    send_addr(addr, 1'b0);
    master_valid = 1'b0;
    wr_bus       = 1'b0;
    check("rd_err", slave_err, 32'(!model_in_range(int'(addr))));
    check("rd_ready_low", slave_ready, 0);
    check("rd_bus_pre", rd_bus, 0);
    @(negedge clk);
    while (got < DW && t < 64) begin
      check("sv_high", slave_valid, 1);
      if (held) check("rd_hold", rd_bus, prev);
      case (ready_mode)
        0:       mr = 1'b1;
        1:       mr = (t % 3) == 0;
        default: mr = 1'($urandom_range(0, 1));
      endcase
      master_ready = mr;
      if (mr && slave_valid) begin
        w = {w[DW-2:0], rd_bus};
        got++;
      end
      prev = rd_bus;
      held = !mr;
      @(negedge clk);
      t++;
    end
    master_ready = 1'b0;
    check("rd_count", got, DW);
    check("sv_end", slave_valid, 0);
    check("rd_bus_idle", rd_bus, 0);
    exp = model_in_range(int'(addr)) ? model_mem[int'(addr) - BASE] : '0;
    check("rd_data", w, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rstn = 1'b0; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b1; master_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", slave_ready, 0);
    check("rst_valid", slave_valid, 0);
    check("rst_rd_bus", rd_bus, 0);
    check("rst_err", slave_err, 0);
    master_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("idle_ready", slave_ready, 0);

    // Basic write/read and a stalled read of the same word.
    do_write(16'h0005, 8'hA5);
    @(negedge clk);
    check("wr_err_gone", slave_err, 0);
    do_read(16'h0005, 0);
    do_read(16'h0005, 1);

    // Aborts in the address field and in the data field leave memory untouched.
    do_write(16'h0003, 8'h3C);
    mode = 1'b1;
    a = 16'h0003;
    for (int i = AW - 1; i >= AW - 10; i--) put_bit(a[i]);
    master_valid = 1'b0;
    @(negedge clk);
    check("abort_addr_idle", slave_ready, 0);
    check("abort_addr_err", slave_err, 0);
    send_addr(16'h0003, 1'b1);
    d = 8'hC3;
    for (int i = DW - 1; i >= DW - 4; i--) put_bit(d[i]);
    master_valid = 1'b0;
    @(negedge clk);
    check("abort_data_idle", slave_ready, 0);
    check("abort_data_err", slave_err, 0);
    @(negedge clk);
    do_read(16'h0003, 0);

    // Map boundaries: last word in range, first word past it, and the top of the space.
    do_write(16'h0000, 8'h5A);
    do_write(16'h003F, 8'h77);
    do_write(16'h0040, 8'hFF);
    @(negedge clk);
    check("oor_err_pulse", slave_err, 0);
    do_read(16'h0040, 0);
    do_read(16'h0000, 0);
    do_read(16'h003F, 2);
    do_read(16'hFFFF, 0);

    // Reset in the middle of SEND.
    send_addr(16'h0005, 1'b0);
    master_valid = 1'b0;
    @(negedge clk);
    master_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_send_valid", slave_valid, 1);
    rstn = 1'b0;
    master_valid = 1'b1;
    @(negedge clk);
    check("rst_send_valid", slave_valid, 0);
    check("rst_send_rd_bus", rd_bus, 0);
    check("rst_send_ready", slave_ready, 0);
    check("rst_send_err", slave_err, 0);
    @(negedge clk);
    check("rst_hold_ready", slave_ready, 0);
    rstn = 1'b1; master_valid = 1'b0; master_ready = 1'b0;
    @(negedge clk);
    do_read(16'h0005, 0);

    // Reset during WRITE blocks the store.
    do_write(16'h0007, 8'h11);
    send_addr(16'h0007, 1'b1);
    d = 8'hEE;
    for (int i = DW - 1; i >= 0; i--) put_bit(d[i]);
    master_valid = 1'b0;
    check("wr2_ready_low", slave_ready, 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_read(16'h0007, 0);

    // Back-to-back writes: the second frame enters ADDR two cycles after WRITE.
    do_write(16'h0010, 8'h96);
    a = 16'h0011;
    mode = 1'b1; master_valid = 1'b1; wr_bus = a[AW-1];
    @(negedge clk);
    check("b2b_idle", slave_ready, 0);
    @(negedge clk);
    check("b2b_addr", slave_ready, 1);
    do_write(16'h0011, 8'h69);
    do_read(16'h0010, 0);
    do_read(16'h0011, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int r = int'($urandom_range(0, 9));
      if (r == 0) a = 16'($urandom);
      else a = 16'(BASE + int'($urandom_range(0, DEPTH + 7)));
      if ($urandom_range(0, 1) == 1 ||
          (model_in_range(int'(a)) && !model_written[int'(a) - BASE])) begin
        do_write(a, 8'($urandom));
      end else begin
        do_read(a, 2);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
